// File: rtl/xalu_ise_issue_pkg.sv
// Shared opcode constants and response-entry layout for the custom-instruction
// issue/writeback stage.
package xalu_ise_issue_pkg;

    localparam int DEFAULT_XLEN = 64;

    localparam logic [1:0] CUSTOM_0 = 2'd0;
    localparam logic [1:0] CUSTOM_1 = 2'd1;
    localparam logic [1:0] CUSTOM_2 = 2'd2;
    localparam logic [1:0] CUSTOM_3 = 2'd3;

    // Layout is fixed at DEFAULT_XLEN; the FIFO stores it as a flat vector.
    typedef struct packed {
        logic [4:0]              rd;
        logic [DEFAULT_XLEN-1:0] data;
        logic                    illegal;
    } rsp_entry_t;

endpackage

// File: rtl/xalu_ise_issue_if.sv
// Core-side request and writeback handshakes of the custom-instruction issue stage.
interface xalu_ise_issue_if
    import xalu_ise_issue_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) ();

    logic            req_valid;
    logic            req_ready;
    logic [4:0]      req_fn;
    logic [6:0]      req_imm;
    logic [XLEN-1:0] req_rs1;
    logic [XLEN-1:0] req_rs2;
    logic [4:0]      req_rd;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [4:0]      rsp_rd;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_illegal;

    // master = core (decode + writeback), slave = issue stage
    modport master (
        output req_valid, req_fn, req_imm, req_rs1, req_rs2, req_rd, rsp_ready,
        input  req_ready, rsp_valid, rsp_rd, rsp_data, rsp_illegal
    );

    modport slave (
        input  req_valid, req_fn, req_imm, req_rs1, req_rs2, req_rd, rsp_ready,
        output req_ready, rsp_valid, rsp_rd, rsp_data, rsp_illegal
    );

endinterface

// File: rtl/xalu_ise_issue_rsp_fifo.sv
// Small synchronous response FIFO with occupancy count; head reads as zero when empty.
module ise_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 70,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // NOTE: storage is deliberately left out of reset; count/valid gate every read,
    // so stale contents are never observable and the array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push && rst_n && !clr) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every reader
    // in the same edge sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign valid = (count != '0);
    assign rdata = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/xalu_ise_issue.sv
// Issue/writeback stage: registers custom-opcode operands for the ALU, then buffers
// {rd, result, illegal} in a credit-protected response FIFO drained by writeback.
module xalu_ise_issue
    import xalu_ise_issue_pkg::*;
#(
    parameter int XLEN      = DEFAULT_XLEN,
    parameter int RSP_DEPTH = 2
) (
    input  logic            ise_clk,
    input  logic            ise_rst,
    input  logic            flush,
    xalu_ise_issue_if.slave bus,
    output logic            alu_val,
    output logic [4:0]      alu_fn,
    output logic [6:0]      alu_imm,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    input  logic            alu_oval,
    input  logic [XLEN-1:0] alu_out
);

    localparam int CNT_W   = $clog2(RSP_DEPTH + 1);
    localparam int ENTRY_W = $bits(rsp_entry_t);

    logic             s1_v;
    logic [4:0]       s1_rd;
    logic [CNT_W-1:0] count;
    logic             accept;
    logic             push;
    logic             pop;
    logic             head_valid;
    rsp_entry_t       push_entry;
    rsp_entry_t       head_entry;

    // Credit uses pre-edge occupancy only, keeping rsp_ready off the req_ready path.
    assign bus.req_ready = !flush && ((int'(count) + int'(s1_v)) < RSP_DEPTH);
    assign accept        = bus.req_valid && bus.req_ready;

    always_ff @(posedge ise_clk) begin
        if (!ise_rst) begin
            s1_v    <= 1'b0;
            s1_rd   <= '0;
            alu_fn  <= '0;
            alu_imm <= '0;
            alu_in1 <= '0;
            alu_in2 <= '0;
        end else begin
            s1_v <= accept;
            if (accept) begin
                s1_rd   <= bus.req_rd;
                alu_fn  <= bus.req_fn;
                alu_imm <= bus.req_imm;
                alu_in1 <= bus.req_rs1;
                alu_in2 <= bus.req_rs2;
            end
        end
    end

    assign alu_val = s1_v;

    // An unclaimed op still produces exactly one (zeroed, flagged) response.
    always_comb begin
        push_entry         = '0;
        push_entry.rd      = s1_rd;
        push_entry.data    = alu_oval ? alu_out : '0;
        push_entry.illegal = !alu_oval;
    end

    assign push = s1_v && !flush;
    assign pop  = head_valid && bus.rsp_ready;

    ise_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_rsp_fifo (
        .clk   (ise_clk),
        .rst_n (ise_rst),
        .clr   (flush),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head_entry),
        .valid (head_valid),
        .count (count)
    );

    assign bus.rsp_valid   = head_valid;
    assign bus.rsp_rd      = head_entry.rd;
    assign bus.rsp_data    = head_entry.data;
    assign bus.rsp_illegal = head_entry.illegal;

endmodule

// File: tb/tb_xalu_ise_issue.sv
// Self-checking bench: plays the core and the ALU, predicts responses from the
// request stream and compares what the writeback port actually delivers.
module tb_xalu_ise_issue;
    import xalu_ise_issue_pkg::*;

    localparam int XLEN = 64;

    typedef struct packed {
        logic            ok;
        logic [XLEN-1:0] d;
    } alu_res_t;

    typedef struct packed {
        logic [4:0]      fn;
        logic [6:0]      imm;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [4:0]      rd;
    } req_t;

    logic            ise_clk = 1'b0;
    logic            ise_rst = 1'b0;
    logic            flush = 1'b0;
    logic            alu_val;
    logic [4:0]      alu_fn;
    logic [6:0]      alu_imm;
    logic [XLEN-1:0] alu_in1;
    logic [XLEN-1:0] alu_in2;
    logic            alu_oval;
    logic [XLEN-1:0] alu_out;

    xalu_ise_issue_if #(.XLEN(XLEN)) bus ();

    xalu_ise_issue #(.XLEN(XLEN), .RSP_DEPTH(2)) dut (
        .ise_clk  (ise_clk),
        .ise_rst  (ise_rst),
        .flush    (flush),
        .bus      (bus),
        .alu_val  (alu_val),
        .alu_fn   (alu_fn),
        .alu_imm  (alu_imm),
        .alu_in1  (alu_in1),
        .alu_in2  (alu_in2),
        .alu_oval (alu_oval),
        .alu_out  (alu_out)
    );

    always #5 ise_clk = ~ise_clk;

    int checks = 0;
    int failures = 0;
    int spurious = 0;
    logic last_acc = 1'b0;
    rsp_entry_t exp_pend[$];
    rsp_entry_t got_log[$];
    rsp_entry_t exp_log[$];

    // Reference ALU: rotate-right-immediate on custom-0, xnor/pack on custom-2.
    function automatic alu_res_t alu_model(logic [4:0] fn, logic [6:0] imm,
                                           logic [XLEN-1:0] a, logic [XLEN-1:0] b);
        alu_res_t r;
        logic [2*XLEN-1:0] dbl;
        r = '0;
        if (fn == {3'b000, CUSTOM_0}) begin
            dbl  = {a, a} >> imm[5:0];
            r.ok = 1'b1;
            r.d  = dbl[XLEN-1:0];
        end else if (fn == {3'b000, CUSTOM_2} && imm == 7'd0) begin
            r.ok = 1'b1;
            r.d  = ~(a ^ b);
        end else if (fn == {3'b000, CUSTOM_2} && imm == 7'd1) begin
            r.ok = 1'b1;
            r.d  = {b[31:0], a[31:0]};
        end
        return r;
    endfunction

    function automatic rsp_entry_t expect_entry(req_t q);
        alu_res_t   r;
        rsp_entry_t e;
        r         = alu_model(q.fn, q.imm, q.rs1, q.rs2);
        e.rd      = q.rd;
        e.data    = r.ok ? r.d : '0;
        e.illegal = !r.ok;
        return e;
    endfunction

    function automatic req_t rand_req();
        req_t q;
        q.rs1 = {$urandom, $urandom};
        q.rs2 = {$urandom, $urandom};
        q.rd  = 5'($urandom);
        case ($urandom_range(0, 3))
            0:       begin q.fn = 5'd0; q.imm = {1'b0, 6'($urandom)}; end
            1:       begin q.fn = 5'd2; q.imm = 7'd0; end
            2:       begin q.fn = 5'd2; q.imm = 7'd1; end
            default: begin q.fn = 5'($urandom_range(1, 31)); q.imm = 7'($urandom);
                           if (q.fn == 5'd2) q.fn = 5'd3; end
        endcase
        return q;
    endfunction

    always_comb begin
        alu_res_t r;
        r        = alu_model(alu_fn, alu_imm, alu_in1, alu_in2);
        alu_oval = r.ok;
        alu_out  = r.ok ? r.d : 64'hDEAD_BEEF_0BAD_F00D;
    end

    task automatic drive_req(req_t q);
        bus.req_valid = 1'b1;
        bus.req_fn    = q.fn;
        bus.req_imm   = q.imm;
        bus.req_rs1   = q.rs1;
        bus.req_rs2   = q.rs2;
        bus.req_rd    = q.rd;
    endtask

    // One clock: sample handshakes mid-cycle, update the transaction model at the edge.
    task automatic tick();
        logic acc, pop, fl, rs;
        rsp_entry_t e, g;
        req_t q;
        @(negedge ise_clk);
        acc = bus.req_valid && bus.req_ready;
        pop = bus.rsp_valid && bus.rsp_ready;
        fl  = flush;
        rs  = ise_rst;
        q   = '{fn: bus.req_fn, imm: bus.req_imm, rs1: bus.req_rs1, rs2: bus.req_rs2, rd: bus.req_rd};
        e   = expect_entry(q);
        g   = '{rd: bus.rsp_rd, data: bus.rsp_data, illegal: bus.rsp_illegal};
        @(posedge ise_clk);
        last_acc = acc && rs;
        if (!rs || fl) begin
            exp_pend.delete();
        end else begin
            if (pop) begin
                if (exp_pend.size() == 0) spurious++;
                else begin
                    exp_log.push_back(exp_pend.pop_front());
                    got_log.push_back(g);
                end
            end
            if (acc) exp_pend.push_back(e);
        end
        #1;
    endtask

    task automatic drain(int max_cycles);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_pend.size() == 0 && !bus.rsp_valid) break;
            tick();
        end
        bus.rsp_ready = 1'b0;
    endtask

    task automatic issue_n(req_t reqs[3], int n, int max_cycles, output int accepted);
        accepted = 0;
        drive_req(reqs[0]);
        for (int i = 0; i < max_cycles && accepted < n; i++) begin
            tick();
            if (last_acc) begin
                accepted++;
                if (accepted < n) drive_req(reqs[accepted]);
                else bus.req_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
        bus.req_fn = '0; bus.req_imm = '0; bus.req_rs1 = '0; bus.req_rs2 = '0; bus.req_rd = '0;
        ise_rst = 1'b0;
        tick(); tick();
        checks++; if (alu_val !== 1'b0) begin failures++; $display("FAIL reset alu_val got=%0h want=0", alu_val); end
        checks++; if ({alu_fn, alu_imm, alu_in1, alu_in2} !== '0) begin failures++; $display("FAIL reset alu_fields got=%h want=0", {alu_fn, alu_imm, alu_in1, alu_in2}); end
        checks++; if ({bus.rsp_valid, bus.rsp_rd, bus.rsp_data, bus.rsp_illegal} !== '0) begin failures++; $display("FAIL reset rsp got=%h want=0", {bus.rsp_valid, bus.rsp_rd, bus.rsp_data, bus.rsp_illegal}); end
        ise_rst = 1'b1;
        tick();
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset req_ready got=%0h want=1", bus.req_ready); end
    endtask

    task automatic test_rori();
        req_t q = '{fn: 5'b00000, imm: 7'b0000100, rs1: 64'hF1, rs2: 64'h0, rd: 5'd5};
        drive_req(q);
        tick();
        bus.req_valid = 1'b0;
        checks++; if (alu_val !== 1'b1 || alu_in1 !== 64'hF1 || alu_imm !== 7'd4) begin failures++; $display("FAIL rori alu_stage got=%0h/%h/%h want=1/f1/4", alu_val, alu_in1, alu_imm); end
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL rori early_rsp got=%0h want=0", bus.rsp_valid); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL rori rsp_valid got=%0h want=1", bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 64'h100000000000000F || bus.rsp_rd !== 5'd5 || bus.rsp_illegal !== 1'b0)
            begin failures++; $display("FAIL rori rsp got=%h rd=%0d ill=%0h want=100000000000000f rd=5 ill=0", bus.rsp_data, bus.rsp_rd, bus.rsp_illegal); end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL rori after_pop got=%0h want=0", bus.rsp_valid); end
    endtask

    task automatic test_back_to_back();
        req_t xn = '{fn: 5'b00010, imm: 7'd0, rs1: 64'h0, rs2: 64'h0, rd: 5'd7};
        req_t pk = '{fn: 5'b00010, imm: 7'd1, rs1: 64'h1111_2222_3333_4444, rs2: 64'h5555_6666_7777_8888, rd: 5'd8};
        int mark = got_log.size();
        bus.rsp_ready = 1'b1;
        drive_req(xn);
        tick();
        checks++; if (last_acc !== 1'b1 || bus.req_ready !== 1'b1) begin failures++; $display("FAIL b2b first_accept acc=%0h ready=%0h want=1/1", last_acc, bus.req_ready); end
        drive_req(pk);
        tick();
        bus.req_valid = 1'b0;
        checks++; if (last_acc !== 1'b1) begin failures++; $display("FAIL b2b second_accept got=%0h want=1", last_acc); end
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 64'hFFFF_FFFF_FFFF_FFFF || bus.rsp_rd !== 5'd7)
            begin failures++; $display("FAIL b2b xnor got=%0h %h rd=%0d want=1 ffffffffffffffff rd=7", bus.rsp_valid, bus.rsp_data, bus.rsp_rd); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 64'h7777_8888_3333_4444 || bus.rsp_rd !== 5'd8)
            begin failures++; $display("FAIL b2b pack got=%0h %h rd=%0d want=1 7777888833334444 rd=8", bus.rsp_valid, bus.rsp_data, bus.rsp_rd); end
        tick();
        bus.rsp_ready = 1'b0;
        checks++; if (got_log.size() - mark !== 2) begin failures++; $display("FAIL b2b resp_count got=%0d want=2", got_log.size() - mark); end
    endtask

    task automatic test_illegal();
        req_t q = '{fn: 5'b00001, imm: 7'h7F, rs1: 64'h1234, rs2: 64'h5678, rd: 5'd9};
        drive_req(q);
        tick();
        bus.req_valid = 1'b0;
        tick();
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_illegal !== 1'b1 || bus.rsp_data !== 64'h0 || bus.rsp_rd !== 5'd9)
            begin failures++; $display("FAIL illegal rsp got=%0h ill=%0h %h rd=%0d want=1 ill=1 0 rd=9", bus.rsp_valid, bus.rsp_illegal, bus.rsp_data, bus.rsp_rd); end
        drain(8);
    endtask

    task automatic test_backpressure();
        req_t reqs[3];
        int acc;
        int mark = got_log.size();
        for (int i = 0; i < 3; i++) reqs[i] = rand_req();
        bus.rsp_ready = 1'b0;
        issue_n(reqs, 3, 8, acc);
        checks++; if (acc !== 2) begin failures++; $display("FAIL bp accepted_while_stalled got=%0d want=2", acc); end
        checks++; if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL bp stalled ready=%0h rsp_valid=%0h want=0/1", bus.req_ready, bus.rsp_valid); end
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 10 && !last_acc; i++) tick();
        bus.req_valid = 1'b0;
        drain(12);
        checks++; if (got_log.size() - mark !== 3) begin failures++; $display("FAIL bp resp_count got=%0d want=3", got_log.size() - mark); end
        for (int i = 0; i < 3 && mark + i < got_log.size(); i++) begin
            checks++; if (got_log[mark+i] !== expect_entry(reqs[i])) begin failures++; $display("FAIL bp resp[%0d] got=%h want=%h", i, got_log[mark+i], expect_entry(reqs[i])); end
        end
    endtask

    task automatic test_flush();
        req_t reqs[3];
        int acc;
        int mark;
        for (int i = 0; i < 3; i++) reqs[i] = rand_req();
        bus.rsp_ready = 1'b0;
        issue_n(reqs, 2, 8, acc);
        flush = 1'b1;
        drive_req(reqs[2]);
        #1;
        checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL flush ready_in_flush got=%0h want=0", bus.req_ready); end
        tick();
        flush = 1'b0;
        #1;
        checks++; if (bus.rsp_valid !== 1'b0 || alu_val !== 1'b0 || bus.req_ready !== 1'b1)
            begin failures++; $display("FAIL flush after rsp_valid=%0h alu_val=%0h ready=%0h want=0/0/1", bus.rsp_valid, alu_val, bus.req_ready); end
        mark = got_log.size();
        bus.rsp_ready = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        drain(8);
        checks++; if (got_log.size() - mark !== 1) begin failures++; $display("FAIL flush resp_count got=%0d want=1", got_log.size() - mark); end
        else begin
            checks++; if (got_log[mark] !== expect_entry(reqs[2])) begin failures++; $display("FAIL flush resp got=%h want=%h", got_log[mark], expect_entry(reqs[2])); end
        end
    endtask

    task automatic test_reset_mid();
        req_t reqs[3];
        int acc;
        int mark;
        for (int i = 0; i < 3; i++) reqs[i] = rand_req();
        bus.rsp_ready = 1'b0;
        issue_n(reqs, 2, 8, acc);
        tick();
        ise_rst = 1'b0;
        tick();
        checks++; if ({alu_val, alu_fn, alu_imm, alu_in1, alu_in2} !== '0) begin failures++; $display("FAIL rst_mid alu got=%h want=0", {alu_val, alu_fn, alu_imm, alu_in1, alu_in2}); end
        checks++; if ({bus.rsp_valid, bus.rsp_rd, bus.rsp_data, bus.rsp_illegal} !== '0) begin failures++; $display("FAIL rst_mid rsp got=%h want=0", {bus.rsp_valid, bus.rsp_rd, bus.rsp_data, bus.rsp_illegal}); end
        ise_rst = 1'b1;
        mark = got_log.size();
        drive_req(reqs[2]);
        bus.rsp_ready = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        drain(8);
        checks++; if (got_log.size() - mark !== 1) begin failures++; $display("FAIL rst_mid resp_count got=%0d want=1", got_log.size() - mark); end
        else begin
            checks++; if (got_log[mark] !== expect_entry(reqs[2])) begin failures++; $display("FAIL rst_mid resp got=%h want=%h", got_log[mark], expect_entry(reqs[2])); end
        end
    endtask

    task automatic test_random();
        int mark = got_log.size();
        int spur0 = spurious;
        int accepted = 0;
        for (int c = 0; c < 600; c++) begin
            if (!bus.req_valid || last_acc || flush) begin
                if ($urandom_range(0, 9) < 7) drive_req(rand_req());
                else bus.req_valid = 1'b0;
            end
            bus.rsp_ready = ($urandom_range(0, 9) < 6);
            flush = ($urandom_range(0, 99) < 3);
            tick();
            if (last_acc) accepted++;
        end
        flush = 1'b0;
        drain(20);
        checks++; if (exp_pend.size() !== 0) begin failures++; $display("FAIL rand undrained got=%0d want=0", exp_pend.size()); end
        checks++; if (spurious !== spur0) begin failures++; $display("FAIL rand spurious got=%0d want=%0d", spurious, spur0); end
        checks++; if (accepted < 50) begin failures++; $display("FAIL rand too_few_accepts got=%0d want>=50", accepted); end
        for (int i = mark; i < got_log.size(); i++) begin
            checks++; if (got_log[i] !== exp_log[i]) begin failures++; $display("FAIL rand resp[%0d] got=%h want=%h", i - mark, got_log[i], exp_log[i]); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_rori();
        test_back_to_back();
        test_illegal();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
